// File: rtl/qsn_sched_len17_if.sv
`default_nettype none
// ============================================================================
// Module   : qsn_sched_len17_if
// Purpose  : Handshake/bus bundle between the QSN issue sequencer and its peers.
// Revision : 1.0 - initial release
// ============================================================================
interface qsn_sched_len17_if #(
    parameter int COL_W   = 4,
    parameter int LAYER_W = 2
);
    logic               cfg_we;
    logic [LAYER_W-1:0] cfg_layer;
    logic [COL_W-1:0]   cfg_col;
    logic [4:0]         cfg_shift;
    logic               start;
    logic [LAYER_W-1:0] layer_id;
    logic               hold;
    logic               busy;
    logic               done;
    logic               msg_rd_en;
    logic [COL_W-1:0]   msg_rd_col;
    logic [4:0]         left_sel;
    logic [4:0]         right_sel;
    logic [15:0]        merge_sel;
    logic               out_valid;
    logic [COL_W-1:0]   out_col;
    logic               shift_err;

    modport master (
        output cfg_we, cfg_layer, cfg_col, cfg_shift, start, layer_id, hold,
        input  busy, done, msg_rd_en, msg_rd_col, left_sel, right_sel,
               merge_sel, out_valid, out_col, shift_err
    );

    modport slave (
        input  cfg_we, cfg_layer, cfg_col, cfg_shift, start, layer_id, hold,
        output busy, done, msg_rd_en, msg_rd_col, left_sel, right_sel,
               merge_sel, out_valid, out_col, shift_err
    );
endinterface
`default_nettype wire

// File: rtl/qsn_sched_len17.sv
`default_nettype none
// ============================================================================
// Module   : qsn_sched_len17
// Purpose  : Column issue sequencer and shift-control generator for the
//            17-wide quasi-cyclic shift network.
// Revision : 1.0 - initial release
// ============================================================================
module qsn_sched_len17 #(
    parameter int COL_NUM   = 10,
    parameter int LAYER_NUM = 4,
    parameter int MEM_LAT   = 1,
    parameter int QSN_LAT   = 2
) (
    input  wire logic        sys_clk,
    input  wire logic        rstn,
    qsn_sched_len17_if.slave bus
);
    localparam int COL_W      = (COL_NUM   > 1) ? $clog2(COL_NUM)   : 1;
    localparam int LAYER_W    = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
    localparam int c_TOT_LAT  = MEM_LAT + QSN_LAT;
    localparam int c_TAG_BITS = c_TOT_LAT * COL_W;
    localparam int c_SEL_BITS = MEM_LAT * 5;
    localparam int c_MRG_BITS = MEM_LAT * 16;

    localparam logic [c_TOT_LAT-1:0]  c_LAST_ONLY  = c_TOT_LAT'(1) << (c_TOT_LAT - 1);
    localparam logic [COL_W-1:0]      c_LAST_COL   = COL_W'(COL_NUM - 1);
    localparam logic [15:0]           c_MERGE_IDLE = 16'hFFFF;
    localparam logic [c_MRG_BITS-1:0] c_MRG_IDLE   = {MEM_LAT{c_MERGE_IDLE}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [LAYER_W-1:0]  layer_q;
    logic [COL_W-1:0]    col_q;

    logic [4:0]          table_q [LAYER_NUM][COL_NUM];

    logic [c_TOT_LAT-1:0]  vld_q;
    logic [c_TOT_LAT-1:0]  vld_d;
    logic [c_TAG_BITS-1:0] tag_q;
    logic [c_SEL_BITS-1:0] lsel_q;
    logic [c_SEL_BITS-1:0] rsel_q;
    logic [c_MRG_BITS-1:0] msel_q;

    logic              w_issue;
    logic              w_illegal;
    logic [4:0]        w_raw;
    logic [4:0]        w_shift;
    logic [4:0]        w_thr;
    logic [4:0]        w_left;
    logic [4:0]        w_right;
    logic [15:0]       w_merge;
    logic [COL_W-1:0]  w_tag_in;

    // Issue decision, table lookup and shift-to-select mapping for this cycle.
    always_comb begin
        w_issue   = (state_q == S_RUN) && !bus.hold;
        w_raw     = (int'(layer_q) < LAYER_NUM) ? table_q[layer_q][col_q] : 5'd0;
        w_illegal = w_issue && (w_raw > 5'd16);
        w_shift   = (w_raw > 5'd16) ? 5'd0 : w_raw;
        w_thr     = 5'd17 - w_shift;
        w_left    = 5'd0;
        w_right   = 5'd0;
        w_merge   = c_MERGE_IDLE;
        w_tag_in  = '0;
        if (w_issue) begin
            w_left   = w_shift;
            w_right  = (w_shift == 5'd0) ? 5'd0 : w_thr;
            w_tag_in = col_q;
            // Lane k takes the left-shifted word while k+s stays below 17.
            for (int k = 0; k < 16; k++) begin
                w_merge[k] = (5'(k) < w_thr);
            end
        end
        vld_d = c_TOT_LAT'({vld_q, w_issue});
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (w_issue && (col_q == c_LAST_COL)) state_d = S_DRAIN;
            S_DRAIN: if (done_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // done is predicted one cycle early so it lands on the final out_valid.
    always_ff @(posedge sys_clk) begin
        if (rstn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            layer_q <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DRAIN) && (vld_d == c_LAST_ONLY);
            if (w_illegal) begin
                err_q <= 1'b1;
            end
            if ((state_q == S_IDLE) && bus.start) begin
                layer_q <= bus.layer_id;
                col_q   <= '0;
            end else if (w_issue) begin
                col_q <= (col_q == c_LAST_COL) ? '0 : col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rstn) begin
            for (int l = 0; l < LAYER_NUM; l++) begin
                for (int c = 0; c < COL_NUM; c++) begin
                    table_q[l][c] <= 5'd0;
                end
            end
        end else if (bus.cfg_we && !busy_q &&
                     (int'(bus.cfg_layer) < LAYER_NUM) &&
                     (int'(bus.cfg_col) < COL_NUM)) begin
            table_q[bus.cfg_layer][bus.cfg_col] <= bus.cfg_shift;
        end
    end

    // Sels ride a MEM_LAT-deep shift line; valid/tag ride MEM_LAT+QSN_LAT.
    always_ff @(posedge sys_clk) begin
        if (rstn) begin
            vld_q  <= '0;
            tag_q  <= '0;
            lsel_q <= '0;
            rsel_q <= '0;
            msel_q <= c_MRG_IDLE;
        end else begin
            vld_q  <= vld_d;
            tag_q  <= c_TAG_BITS'({tag_q, w_tag_in});
            lsel_q <= c_SEL_BITS'({lsel_q, w_left});
            rsel_q <= c_SEL_BITS'({rsel_q, w_right});
            msel_q <= c_MRG_BITS'({msel_q, w_merge});
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.shift_err  = err_q;
    assign bus.msg_rd_en  = w_issue;
    assign bus.msg_rd_col = col_q;
    assign bus.left_sel   = lsel_q[c_SEL_BITS-1 -: 5];
    assign bus.right_sel  = rsel_q[c_SEL_BITS-1 -: 5];
    assign bus.merge_sel  = msel_q[c_MRG_BITS-1 -: 16];
    assign bus.out_valid  = vld_q[c_TOT_LAT-1];
    assign bus.out_col    = tag_q[c_TAG_BITS-1 -: COL_W];

endmodule
`default_nettype wire

// File: tb/tb_qsn_sched_len17.sv
`default_nettype none
// ============================================================================
// Module   : tb_qsn_sched_len17
// Purpose  : Scoreboard bench for the QSN issue sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qsn_sched_len17;
    localparam int COL_NUM   = 10;
    localparam int LAYER_NUM = 4;
    localparam int MEM_LAT   = 1;
    localparam int QSN_LAT   = 2;
    localparam int COL_W     = 4;
    localparam int LAYER_W   = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [25:0] sel_q [$];
    int          rd_q  [$];
    int          tag_q [$];

    qsn_sched_len17_if #(.COL_W(COL_W), .LAYER_W(LAYER_W)) bus ();

    qsn_sched_len17 #(
        .COL_NUM   (COL_NUM),
        .LAYER_NUM (LAYER_NUM),
        .MEM_LAT   (MEM_LAT),
        .QSN_LAT   (QSN_LAT)
    ) dut (
        .sys_clk (clk),
        .rstn    (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Hand-computed {left_sel, right_sel, merge_sel} for each shift used.
    function automatic logic [25:0] hand_sel(input int s);
        case (s)
            0:       return {5'd0,  5'd0,  16'hFFFF};
            1:       return {5'd1,  5'd16, 16'hFFFF};
            2:       return {5'd2,  5'd15, 16'h7FFF};
            3:       return {5'd3,  5'd14, 16'h3FFF};
            5:       return {5'd5,  5'd12, 16'h0FFF};
            7:       return {5'd7,  5'd10, 16'h03FF};
            9:       return {5'd9,  5'd8,  16'h00FF};
            12:      return {5'd12, 5'd5,  16'h001F};
            15:      return {5'd15, 5'd2,  16'h0003};
            16:      return {5'd16, 5'd1,  16'h0001};
            20:      return {5'd0,  5'd0,  16'hFFFF};
            default: return 26'h3FFFFFF;
        endcase
    endfunction

    task automatic monitor();
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (sel_q.size() == 0) chk("sel_underflow", 32'd1, 32'd0);
                    else chk("sels", {bus.left_sel, bus.right_sel, bus.merge_sel}, sel_q.pop_front());
                end else begin
                    chk("bubble_sels", {bus.left_sel, bus.right_sel, bus.merge_sel},
                        {5'd0, 5'd0, 16'hFFFF});
                end
                pend = bus.msg_rd_en;
                if (bus.msg_rd_en) begin
                    if (rd_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
                    else chk("rd_col", 32'(bus.msg_rd_col), rd_q.pop_front());
                end
                if (bus.out_valid) begin
                    if (tag_q.size() == 0) chk("tag_underflow", 32'd1, 32'd0);
                    else chk("out_col", 32'(bus.out_col), tag_q.pop_front());
                end
            end
        end
    endtask

    task automatic cfg_write(input int layer, input int col, input int shift);
        bus.cfg_we    = 1'b1;
        bus.cfg_layer = LAYER_W'(layer);
        bus.cfg_col   = COL_W'(col);
        bus.cfg_shift = 5'(shift);
        @(posedge clk); #1;
        bus.cfg_we    = 1'b0;
    endtask

    task automatic run_layer(input string nm, input int layer, input int sh[COL_NUM],
                             input int hs, input int he, input int inj, input int cow,
                             input int exp_done, input logic [31:0] exp_rd,
                             input logic [31:0] exp_ov);
        logic [31:0] rd_m;
        logic [31:0] ov_m;
        int          done_at;
        bit          fin;
        rd_m = '0; ov_m = '0; done_at = -1; fin = 1'b0;
        for (int c = 0; c < COL_NUM; c++) begin
            rd_q.push_back(c);
            tag_q.push_back(c);
            sel_q.push_back(hand_sel(sh[c]));
        end
        bus.start    = 1'b1;
        bus.layer_id = LAYER_W'(layer);
        if (cow >= 0) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_layer = LAYER_W'(layer);
            bus.cfg_col   = '0;
            bus.cfg_shift = 5'(cow);
        end
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        for (int k = 1; k < 32 && !fin; k++) begin
            bus.hold = (k >= hs) && (k <= he);
            if (k == inj) begin
                bus.start     = 1'b1;
                bus.layer_id  = 2'd3;
                bus.cfg_we    = 1'b1;
                bus.cfg_layer = 2'd0;
                bus.cfg_col   = 4'd0;
                bus.cfg_shift = 5'd9;
            end
            @(negedge clk);
            if (k == 1) chk({nm, " busy_c1"}, 32'(bus.busy), 32'd1);
            if (bus.msg_rd_en) rd_m[k] = 1'b1;
            if (bus.out_valid) ov_m[k] = 1'b1;
            if (done_at >= 0) begin
                chk({nm, " busy_after_done"}, 32'(bus.busy), 32'd0);
                fin = 1'b1;
            end else if (bus.done) begin
                done_at = k;
            end
            @(posedge clk); #1;
            bus.start  = 1'b0;
            bus.cfg_we = 1'b0;
            bus.hold   = 1'b0;
        end
        chk({nm, " done_cycle"}, 32'(done_at), 32'(exp_done));
        chk({nm, " rd_cycles"}, rd_m, exp_rd);
        chk({nm, " ov_cycles"}, ov_m, exp_ov);
        chk({nm, " sb_empty"}, 32'(rd_q.size() + tag_q.size() + sel_q.size()), 32'd0);
    endtask

    initial begin
        int l0[COL_NUM];
        int l1[COL_NUM];
        int l2[COL_NUM];
        int l2w[COL_NUM];
        int zr[COL_NUM];
        int done_seen;
        l0  = '{0, 1, 5, 16, 2, 3, 7, 9, 15, 12};
        l1  = '{3, 7, 20, 9, 1, 16, 0, 12, 5, 2};
        l2w = '{0, 16, 1, 12, 15, 9, 2, 5, 3, 0};
        l2  = '{7, 16, 1, 12, 15, 9, 2, 5, 3, 0};
        zr  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_layer = '0; bus.cfg_col = '0; bus.cfg_shift = '0;
        bus.start = 1'b0; bus.layer_id = '0; bus.hold = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ctrl", {bus.busy, bus.done, bus.msg_rd_en, bus.msg_rd_col, bus.out_valid,
                           bus.out_col, bus.shift_err}, 32'd0);
        chk("reset_sels", {bus.left_sel, bus.right_sel, bus.merge_sel}, {5'd0, 5'd0, 16'hFFFF});
        @(posedge clk); #1;
        rst = 1'b0;

        for (int c = 0; c < COL_NUM; c++) cfg_write(0, c, l0[c]);
        for (int c = 0; c < COL_NUM; c++) cfg_write(1, c, l1[c]);
        for (int c = 1; c < COL_NUM; c++) cfg_write(2, c, l2w[c]);
        chk("err_initial", 32'(bus.shift_err), 32'd0);

        run_layer("map", 0, l0, 0, -1, 0, -1, 13, 32'h0000_07FE, 32'h0000_3FF0);
        run_layer("hold", 0, l0, 3, 4, 0, -1, 15, 32'h0000_1FE6, 32'h0000_FF30);
        run_layer("illegal", 1, l1, 0, -1, 0, -1, 13, 32'h0000_07FE, 32'h0000_3FF0);
        chk("err_set", 32'(bus.shift_err), 32'd1);
        run_layer("ignored", 2, l2, 0, -1, 5, 7, 13, 32'h0000_07FE, 32'h0000_3FF0);
        run_layer("unchanged", 0, l0, 0, -1, 0, -1, 13, 32'h0000_07FE, 32'h0000_3FF0);
        chk("err_sticky", 32'(bus.shift_err), 32'd1);

        // Abort a run while column 4 is being read.
        for (int c = 0; c < COL_NUM; c++) begin
            rd_q.push_back(c);
            tag_q.push_back(c);
            sel_q.push_back(hand_sel(l0[c]));
        end
        bus.start = 1'b1; bus.layer_id = 2'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rd_col4_at_reset", 32'(bus.msg_rd_col), 32'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_q.delete(); tag_q.delete(); sel_q.delete();
        @(negedge clk);
        chk("midrst_ctrl", {bus.busy, bus.done, bus.msg_rd_en, bus.msg_rd_col, bus.out_valid,
                            bus.out_col, bus.shift_err}, 32'd0);
        chk("midrst_sels", {bus.left_sel, bus.right_sel, bus.merge_sel}, {5'd0, 5'd0, 16'hFFFF});
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("no_done_after_abort", 32'(done_seen), 32'd0);
        @(posedge clk); #1;
        run_layer("fresh", 0, zr, 0, -1, 0, -1, 13, 32'h0000_07FE, 32'h0000_3FF0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/qsn_sched_len17.md
# qsn_sched_len17

Issue sequencer and shift-control generator for the 17-wide, 4-bit quasi-cyclic shift network (QSN). It sits directly upstream of the QSN. On a layer start it walks the column blocks of that layer in order and issues message-memory reads. It converts each stored shift factor into the QSN's `left_sel`, `right_sel` and `merge_sel`, time-aligned with the memory read data. It also emits a valid/column tag aligned with the QSN's registered output, so the downstream writer knows which column each shifted vector belongs to.

## Interface
Parameters:
- `COL_NUM`, default 10: column blocks per layer, at least 1.
- `LAYER_NUM`, default 4: layers held in the shift table.
- `MEM_LAT`, default 1: message-memory read latency in cycles, at least 1.
- `QSN_LAT`, default 2: QSN latency from `sel`/`sw_in` to `sw_out`, in cycles.
- `COL_W` = clog2(`COL_NUM`), `LAYER_W` = clog2(`LAYER_NUM`); both derived.

Ports:
- `sys_clk` in, 1: the only clock.
- `rstn` in, 1: **synchronous, active-high reset.** Asserted = 1.
- `cfg_we` in, 1: shift-table write strobe.
- `cfg_layer` in, `LAYER_W`: table write layer.
- `cfg_col` in, `COL_W`: table write column.
- `cfg_shift` in, 5: shift factor, legal range 0..16.
- `start` in, 1: layer start pulse.
- `layer_id` in, `LAYER_W`: layer to run; sampled when `start` is accepted.
- `hold` in, 1: suspends read issue.
- `busy` out, 1: high from accepted `start` until after `done`.
- `done` out, 1: one-cycle pulse coincident with the last `out_valid`.
- `msg_rd_en` out, 1: message-memory read strobe.
- `msg_rd_col` out, `COL_W`: column being read.
- `left_sel` out, 5: to QSN.
- `right_sel` out, 5: to QSN.
- `merge_sel` out, 16: to QSN.
- `out_valid` out, 1: QSN `sw_out` holds a valid vector.
- `out_col` out, `COL_W`: column tag of the current `sw_out`.
- `shift_err` out, 1: sticky flag; an illegal shift factor was issued.

## Operation
- **Shift table:** `LAYER_NUM` × `COL_NUM` entries of 5 bits, read combinationally.
  - A write when `cfg_we=1` and `busy=0` lands at the next edge.
  - `cfg_we` while `busy=1` is ignored.
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE: `start=1` latches `layer_id`, clears the column counter and goes to RUN. `start` in any other state is ignored.
  - RUN: each cycle with `hold=0`, assert `msg_rd_en` with `msg_rd_col`=col, then increment col. After issuing col=`COL_NUM`-1, go to DRAIN.
  - RUN with `hold=1`: `msg_rd_en=0` and col is held. The pipeline keeps advancing and the bubble propagates.
  - DRAIN: wait until the valid pipeline is empty, pulse `done` with the last `out_valid`, then return to IDLE. `hold` has no effect in DRAIN.
- **Shift mapping:** for an issued shift s, the required QSN result is out[k] = in[(k+s) mod 17].
  - `left_sel` = s.
  - `right_sel` = (s==0) ? 0 : 17−s.
  - `merge_sel`[k] = 1 iff k < 17−s, for k = 0..15.
- **Illegal shift (s > 16):** treated as s=0 and sets `shift_err`. `shift_err` clears only on reset.
- **Bubble cycles** (no valid issue behind them): `left_sel`=0, `right_sel`=0, `merge_sel`=16'hFFFF.
- **Reset:** all outputs are 0, except `merge_sel`=16'hFFFF. The FSM returns to IDLE, the valid/tag pipeline is cleared and the table is cleared to 0. Reset in the middle of a layer aborts it with no `done`.

## Timing
- The control and tag path is a shift pipeline.
- `left_sel`, `right_sel` and `merge_sel` are registered outputs. They appear exactly `MEM_LAT` cycles after the `msg_rd_en` of the same column, which aligns them with the read data at the QSN `sw_in`.
- `out_valid`/`out_col` appear `QSN_LAT` cycles after the matching sels, i.e. `MEM_LAT`+`QSN_LAT` cycles after `msg_rd_en`.
- With `start` accepted at cycle 0 and `hold` low:
  - `msg_rd_en` in cycles 1..`COL_NUM`.
  - `done` in cycle `COL_NUM`+`MEM_LAT`+`QSN_LAT`.
  - `busy` high from cycle 1 through the `done` cycle, low in the next cycle.
- A new `start` is accepted in the cycle after `done` at the earliest. Back-to-back layers therefore have `MEM_LAT`+`QSN_LAT`+1 idle cycles between them.
- `start` and `cfg_we` in the same cycle while IDLE: the write lands and is visible to that layer's first read.

## Test plan
- **Mapping:** load layer 0 with shifts {0,1,5,16}, start. Require the sels, in order:
  - s=0: `left_sel`=0, `right_sel`=0, `merge_sel`=FFFF.
  - s=1: `left_sel`=1, `right_sel`=16, `merge_sel`=FFFF.
  - s=5: `left_sel`=5, `right_sel`=12, `merge_sel`=0FFF.
  - s=16: `left_sel`=16, `right_sel`=1, `merge_sel`=0001.
- **Latency** (`COL_NUM`=10, `MEM_LAT`=1, `QSN_LAT`=2): `start` at cycle 0.
  - Require `msg_rd_en` in cycles 1..10, sels valid in cycles 2..11, and `out_valid` in cycles 4..13 with `out_col` 0..9.
  - Require `done` in cycle 13 and `busy`=0 in cycle 14.
- **Hold:** assert `hold` in cycles 3..4. Require no read in those cycles, no column skipped or repeated, `out_valid` gaps of 2 cycles, and `done` in cycle 15.
- **Illegal shift:** write shift 20 to col 2 and run. Require col 2 to issue s=0 sels, `shift_err`=1 afterwards, and `shift_err` to stay 1 through the next layer.
- **Ignored inputs:** assert `start` and `cfg_we` while `busy`. Require no restart and the table unchanged.
- **Reset mid-run:** assert `rstn` during RUN at col 4. Require all outputs at reset values the next cycle, no `done`, and a fresh `start` running normally.
